// File: rtl/tt_pkg.sv
// tt_pkg: shared lever controller types and constants.
package tt_pkg;
  typedef enum logic [2:0] {S_IDLE, S_TRIG, S_WAIT_REL, S_FLIGHT, S_HALT, S_DONE, S_ERROR} state_t;
  localparam logic COLOR_BLUE = 1'b0;
  localparam logic COLOR_RED = 1'b1;
  localparam int DROPS_W = 5;
  localparam logic [DROPS_W-1:0] DROPS_MAX = '1;
endpackage

// File: rtl/lever_ctrl_if.sv
// lever_ctrl_if: player/board-stage signals of the lever controller.
interface lever_ctrl_if;
  import tt_pkg::*;
  logic start, exit_blue, exit_red, intercept, blue_ball, red_ball, no_balls;
  logic blue_trigger, red_trigger, in_flight, fault;
  logic [2:0] state_o;
  logic [DROPS_W-1:0] drops;
  modport master(
    output start, exit_blue, exit_red, intercept, blue_ball, red_ball, no_balls,
    input blue_trigger, red_trigger, in_flight, fault, state_o, drops
  );
  modport slave(
    input start, exit_blue, exit_red, intercept, blue_ball, red_ball, no_balls,
    output blue_trigger, red_trigger, in_flight, fault, state_o, drops
  );
endinterface

// File: rtl/tt_edge_det.sv
// tt_edge_det: registered rising-edge detector, silent on the first cycle after reset.
module tt_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);
  logic prev, armed;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= 1'b0;
      armed <= 1'b0;
    end else begin
      prev <= d;
      armed <= 1'b1;
    end
  // armed masks inputs that were already high when reset released
  assign rise = armed && d && !prev;
endmodule

// File: rtl/lever_ctrl.sv
// lever_ctrl: lever trigger sequencer for the ball board.
// Define LEVER_CTRL_WATCHDOG_EN to enable the in-flight timeout.
module lever_ctrl
  import tt_pkg::*;
#(
  parameter int TRIG_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst_n,
  lever_ctrl_if.slave bus
);
  state_t state, next;
  logic color, next_color;
  logic start_e, blue_e, red_e, int_e;
  logic ball, released, rel_win, restart, timeout, fault;
  logic [3:0] cnt;
  logic [DROPS_W-1:0] drops;

  tt_edge_det u_start (.clk(clk), .rst_n(rst_n), .d(bus.start), .rise(start_e));
  tt_edge_det u_blue (.clk(clk), .rst_n(rst_n), .d(bus.exit_blue), .rise(blue_e));
  tt_edge_det u_red (.clk(clk), .rst_n(rst_n), .d(bus.exit_red), .rise(red_e));
  tt_edge_det u_int (.clk(clk), .rst_n(rst_n), .d(bus.intercept), .rise(int_e));

  assign ball = bus.blue_ball || bus.red_ball;
  // WAIT_REL lasts one cycle, so this window is TRIG plus its first cycle
  assign rel_win = state == S_TRIG || state == S_WAIT_REL;
  assign restart = start_e && state inside {S_IDLE, S_HALT, S_DONE, S_ERROR};

`ifdef LEVER_CTRL_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd <= '0;
    else wd <= state == S_FLIGHT ? wd + WD_W'(1) : '0;
  assign timeout = state == S_FLIGHT && wd == WD_W'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      color <= COLOR_BLUE;
    end else begin
      state <= next;
      color <= next_color;
    end

  always_comb begin
    next = state;
    next_color = color;
    case (state)
      S_TRIG: next = cnt == 4'(TRIG_CYCLES - 1) ? S_WAIT_REL : S_TRIG;
      S_WAIT_REL: next = released || ball ? S_FLIGHT : S_DONE;
      S_FLIGHT:
        if (int_e) next = S_HALT;
        else if (blue_e && red_e) next = S_ERROR;
        else if (blue_e || red_e) begin
          next = S_TRIG;
          next_color = red_e ? COLOR_RED : COLOR_BLUE;
        end else if (timeout) next = S_ERROR;
      default:
        if (restart) begin
          next = S_TRIG;
          next_color = COLOR_BLUE;
        end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      released <= 1'b0;
      drops <= '0;
      fault <= 1'b0;
    end else begin
      cnt <= state == S_TRIG ? cnt + 4'd1 : '0;
      released <= rel_win && (released || ball);
      drops <= restart ? '0
             : (rel_win && ball && !released && drops != DROPS_MAX) ? drops + DROPS_W'(1) : drops;
      fault <= restart ? 1'b0 : fault || next == S_ERROR;
    end

  assign bus.blue_trigger = state == S_TRIG && color == COLOR_BLUE;
  assign bus.red_trigger = state == S_TRIG && color == COLOR_RED;
  assign bus.in_flight = state == S_FLIGHT;
  assign bus.state_o = state;
  assign bus.fault = fault;
  assign bus.drops = drops;
endmodule

// File: tb/tb_lever_ctrl.sv
// tb_lever_ctrl: scoreboard bench for lever_ctrl trigger pulses, drops, faults and reset.
module tb_lever_ctrl;
  import tt_pkg::*;
  typedef struct packed {logic col; int len;} pulse_t;

  logic clk, rst_n;
  int tests, fails;
  pulse_t exp_q[$], obs_q[$];
  int mon_len, flight_cnt, last_flight;
  logic mon_col;
  bit both_seen;

  lever_ctrl_if bus();
  lever_ctrl #(.TRIG_CYCLES(4), .TIMEOUT_CYCLES(1024)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_len = 0;
      flight_cnt = 0;
    end else begin
      if (bus.blue_trigger && bus.red_trigger) both_seen = 1'b1;
      if (bus.blue_trigger || bus.red_trigger) begin
        mon_len++;
        mon_col = bus.red_trigger;
      end else if (mon_len > 0) begin
        obs_q.push_back('{col: mon_col, len: mon_len});
        mon_len = 0;
      end
      if (bus.in_flight) flight_cnt++;
      else begin
        if (flight_cnt > 0) last_flight = flight_cnt;
        flight_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(output bit ok);
    for (int i = 0; i < 40 && obs_q.size() == 0; i++) tick();
    ok = obs_q.size() > 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 0; bus.exit_blue = 0; bus.exit_red = 0; bus.intercept = 0;
    bus.blue_ball = 0; bus.red_ball = 0; bus.no_balls = 0;
    tick(); tick();
    tests++; if (bus.state_o !== S_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", bus.state_o, S_IDLE); end
    tests++; if ({bus.blue_trigger, bus.red_trigger, bus.in_flight, bus.fault} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b want 0000", {bus.blue_trigger, bus.red_trigger, bus.in_flight, bus.fault}); end
    tests++; if (bus.drops !== 5'd0) begin fails++; $display("FAIL reset_drops: got %0d want 0", bus.drops); end
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_first_drop();
    bit ok; pulse_t p, e;
    bus.blue_ball = 1;
    exp_q.push_back('{col: COLOR_BLUE, len: 4});
    bus.start = 1; tick(); bus.start = 0;
    wait_pulse(ok);
    bus.blue_ball = 0;
    e = exp_q.pop_front();
    tests++;
    if (!ok) begin fails++; $display("FAIL drop1_pulse: no trigger pulse seen, want col=%0d len=%0d", e.col, e.len); end
    else begin p = obs_q.pop_front(); if (p !== e) begin fails++; $display("FAIL drop1_pulse: got col=%0d len=%0d want col=%0d len=%0d", p.col, p.len, e.col, e.len); end end
    tests++; if (bus.state_o !== S_FLIGHT || bus.in_flight !== 1'b1) begin fails++; $display("FAIL drop1_state: got %0d/%b want %0d/1", bus.state_o, bus.in_flight, S_FLIGHT); end
    tests++; if (bus.drops !== 5'd1) begin fails++; $display("FAIL drop1_drops: got %0d want 1", bus.drops); end
  endtask

  task automatic test_exit_cycle();
    bit ok; pulse_t p, e;
    for (int i = 0; i < 2; i++) begin
      e = '{col: (i == 0) ? COLOR_RED : COLOR_BLUE, len: 4};
      exp_q.push_back(e);
      bus.red_ball = 1;
      if (i == 0) bus.exit_red = 1; else bus.exit_blue = 1;
      tick();
      bus.exit_red = 0; bus.exit_blue = 0;
      wait_pulse(ok);
      bus.red_ball = 0;
      e = exp_q.pop_front();
      tests++;
      if (!ok) begin fails++; $display("FAIL exit%0d_pulse: no trigger pulse seen, want col=%0d", i, e.col); end
      else begin p = obs_q.pop_front(); if (p !== e) begin fails++; $display("FAIL exit%0d_pulse: got col=%0d len=%0d want col=%0d len=%0d", i, p.col, p.len, e.col, e.len); end end
      tests++; if (bus.drops !== 5'(2 + i) || bus.state_o !== S_FLIGHT) begin fails++; $display("FAIL exit%0d_drops: got %0d st %0d want %0d st %0d", i, bus.drops, bus.state_o, 2 + i, S_FLIGHT); end
    end
  endtask

  task automatic test_no_release();
    bit ok; pulse_t p, e;
    bus.no_balls = 1;
    exp_q.push_back('{col: COLOR_BLUE, len: 4});
    bus.exit_blue = 1; tick(); bus.exit_blue = 0;
    wait_pulse(ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok) begin fails++; $display("FAIL norel_pulse: no trigger pulse seen"); end
    else begin p = obs_q.pop_front(); if (p !== e) begin fails++; $display("FAIL norel_pulse: got col=%0d len=%0d want col=%0d len=%0d", p.col, p.len, e.col, e.len); end end
    tests++; if (bus.state_o !== S_DONE || bus.blue_trigger || bus.red_trigger) begin fails++; $display("FAIL norel_state: got %0d want %0d, triggers low", bus.state_o, S_DONE); end
    tests++; if (bus.drops !== 5'd3) begin fails++; $display("FAIL norel_drops: got %0d want 3", bus.drops); end
    bus.exit_blue = 1; tick(); bus.exit_blue = 0; tick(); tick();
    tests++; if (bus.state_o !== S_DONE || obs_q.size() != 0) begin fails++; $display("FAIL done_ignores_exit: got %0d pulses %0d want %0d pulses 0", bus.state_o, obs_q.size(), S_DONE); end
    bus.no_balls = 0;
  endtask

  task automatic test_error_halt();
    bit ok; pulse_t p, e;
    for (int i = 0; i < 2; i++) begin
      bus.blue_ball = 1;
      exp_q.push_back('{col: COLOR_BLUE, len: 4});
      bus.start = 1; tick(); bus.start = 0;
      wait_pulse(ok);
      bus.blue_ball = 0;
      e = exp_q.pop_front();
      tests++;
      if (!ok) begin fails++; $display("FAIL restart%0d_pulse: no trigger pulse seen", i); end
      else begin p = obs_q.pop_front(); if (p !== e) begin fails++; $display("FAIL restart%0d_pulse: got col=%0d len=%0d want col=%0d len=%0d", i, p.col, p.len, e.col, e.len); end end
      tests++; if (bus.drops !== 5'd1 || bus.fault !== 1'b0 || bus.state_o !== S_FLIGHT) begin fails++; $display("FAIL restart%0d_clear: got drops %0d fault %b st %0d want 1 0 %0d", i, bus.drops, bus.fault, bus.state_o, S_FLIGHT); end
      if (i == 0) begin
        bus.exit_blue = 1; bus.exit_red = 1; tick(); bus.exit_blue = 0; bus.exit_red = 0;
        tests++; if (bus.state_o !== S_ERROR || bus.fault !== 1'b1) begin fails++; $display("FAIL dual_exit: got st %0d fault %b want %0d 1", bus.state_o, bus.fault, S_ERROR); end
        repeat (4) tick();
        tests++; if (bus.state_o !== S_ERROR || bus.fault !== 1'b1 || bus.blue_trigger || bus.red_trigger) begin fails++; $display("FAIL error_hold: got st %0d fault %b want %0d 1", bus.state_o, bus.fault, S_ERROR); end
      end
    end
    bus.intercept = 1; bus.exit_red = 1; tick(); bus.intercept = 0; bus.exit_red = 0;
    tests++; if (bus.state_o !== S_HALT || bus.fault !== 1'b0) begin fails++; $display("FAIL intercept_wins: got st %0d fault %b want %0d 0", bus.state_o, bus.fault, S_HALT); end
    repeat (8) tick();
    tests++; if (bus.state_o !== S_HALT || obs_q.size() != 0) begin fails++; $display("FAIL halt_quiet: got st %0d pulses %0d want %0d 0", bus.state_o, obs_q.size(), S_HALT); end
  endtask

  task automatic test_saturation();
    bit ok; pulse_t p, e; int exp_drops; logic r;
    bus.blue_ball = 1;
    exp_q.push_back('{col: COLOR_BLUE, len: 4});
    bus.start = 1; tick(); bus.start = 0;
    exp_drops = 1;
    wait_pulse(ok);
    e = exp_q.pop_front();
    tests++;
    if (!ok) begin fails++; $display("FAIL sat_start: no trigger pulse seen"); end
    else begin p = obs_q.pop_front(); if (p !== e) begin fails++; $display("FAIL sat_start: got col=%0d len=%0d want col=%0d len=%0d", p.col, p.len, e.col, e.len); end end
    for (int i = 0; i < 32; i++) begin
      r = i[0];
      exp_q.push_back('{col: r, len: 4});
      if (r) bus.exit_red = 1; else bus.exit_blue = 1;
      tick();
      bus.exit_red = 0; bus.exit_blue = 0;
      wait_pulse(ok);
      exp_drops = (exp_drops >= 31) ? 31 : exp_drops + 1;
      e = exp_q.pop_front();
      tests++;
      if (!ok) begin fails++; $display("FAIL sat%0d_pulse: no trigger pulse seen", i); end
      else begin p = obs_q.pop_front(); if (p !== e) begin fails++; $display("FAIL sat%0d_pulse: got col=%0d len=%0d want col=%0d len=%0d", i, p.col, p.len, e.col, e.len); end end
      tests++; if (bus.drops !== 5'(exp_drops)) begin fails++; $display("FAIL sat%0d_drops: got %0d want %0d", i, bus.drops, exp_drops); end
    end
    bus.blue_ball = 0;
    tests++; if (both_seen) begin fails++; $display("FAIL trig_exclusive: both triggers seen high together, want never"); end
  endtask

  task automatic test_watchdog();
`ifdef LEVER_CTRL_WATCHDOG_EN
    for (int i = 0; i < 1100 && bus.in_flight; i++) tick();
    tick();
    tests++; if (bus.state_o !== S_ERROR || bus.fault !== 1'b1) begin fails++; $display("FAIL wd_error: got st %0d fault %b want %0d 1", bus.state_o, bus.fault, S_ERROR); end
    tests++; if (last_flight != 1024) begin fails++; $display("FAIL wd_cycles: got %0d flight cycles want 1024", last_flight); end
`else
    repeat (5000) tick();
    tests++; if (bus.state_o !== S_FLIGHT || bus.in_flight !== 1'b1) begin fails++; $display("FAIL no_wd_flight: got st %0d want %0d", bus.state_o, S_FLIGHT); end
    tests++; if (bus.fault !== 1'b0) begin fails++; $display("FAIL no_wd_fault: got %b want 0", bus.fault); end
`endif
  endtask

  task automatic test_reset_mid_pulse();
    bit ok; pulse_t p, e;
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick(); tick();
    exp_q.delete(); obs_q.delete();
    bus.start = 1; tick(); tick();
    tests++; if (bus.blue_trigger !== 1'b1) begin fails++; $display("FAIL mid_pulse_pre: got %b want 1", bus.blue_trigger); end
    #2;
    rst_n = 1'b0;
    bus.exit_blue = 1; bus.exit_red = 1; bus.intercept = 1;
    #1;
    tests++; if ({bus.blue_trigger, bus.red_trigger, bus.in_flight, bus.fault} !== 4'b0) begin fails++; $display("FAIL mid_pulse_async: got %b want 0000", {bus.blue_trigger, bus.red_trigger, bus.in_flight, bus.fault}); end
    tests++; if (bus.state_o !== S_IDLE || bus.drops !== 5'd0) begin fails++; $display("FAIL mid_pulse_regs: got st %0d drops %0d want %0d 0", bus.state_o, bus.drops, S_IDLE); end
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    tests++; if (bus.state_o !== S_IDLE || obs_q.size() != 0) begin fails++; $display("FAIL no_spurious_edge: got st %0d pulses %0d want %0d 0", bus.state_o, obs_q.size(), S_IDLE); end
    bus.start = 0; bus.exit_blue = 0; bus.exit_red = 0; bus.intercept = 0;
    tick();
    bus.blue_ball = 1;
    exp_q.push_back('{col: COLOR_BLUE, len: 4});
    bus.start = 1; tick(); bus.start = 0;
    wait_pulse(ok);
    bus.blue_ball = 0;
    e = exp_q.pop_front();
    tests++;
    if (!ok) begin fails++; $display("FAIL post_reset_start: no trigger pulse seen"); end
    else begin p = obs_q.pop_front(); if (p !== e) begin fails++; $display("FAIL post_reset_start: got col=%0d len=%0d want col=%0d len=%0d", p.col, p.len, e.col, e.len); end end
  endtask

  initial begin
    tests = 0; fails = 0; both_seen = 1'b0; last_flight = 0;
    test_reset();
    test_first_drop();
    test_exit_cycle();
    test_no_release();
    test_error_halt();
    test_saturation();
    test_watchdog();
    test_reset_mid_pulse();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lever_ctrl.md
LEVER_CTRL -- requirements
Module: lever_ctrl

Interface
REQ-001 Parameter TRIG_CYCLES, default 4, width of each trigger pulse in clocks (legal 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1024, max clocks a released ball may stay in flight.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  player pulls blue lever; rising edge starts a run.
REQ-007 exit_blue  input  1  ball reached blue-lever exit at bottom of front cells (level).
REQ-008 exit_red  input  1  ball reached red-lever exit (level).
REQ-009 intercept  input  1  ball caught by interceptor (level).
REQ-010 blue_ball, red_ball  input  1 each  ball-release indications from the board stage.
REQ-011 no_balls  input  1  board stage reports empty supply.
REQ-012 blue_trigger, red_trigger  output  1 each  lever pulses to the board stage.
REQ-013 in_flight  output  1  ball on the front, awaiting exit.
REQ-014 state_o  output  3  current FSM state encoding.
REQ-015 fault  output  1  sticky error (timeout or dual exit).
REQ-016 drops  output  5  number of balls released this run, saturating at 31.

Function
REQ-017 Rising edges of start, exit_blue, exit_red, intercept detected via one registered prior sample; levels ignored.
REQ-018 States: IDLE, TRIG, WAIT_REL, FLIGHT, HALT, DONE, ERROR.
REQ-019 IDLE: start edge -> TRIG with color BLUE, drops cleared, fault cleared.
REQ-020 TRIG: assert selected trigger exactly TRIG_CYCLES clocks, never both triggers together; then -> WAIT_REL.
REQ-021 A blue_ball or red_ball high sampled during TRIG or the first cycle of WAIT_REL latches "released"; drops increments once per pulse.
REQ-022 WAIT_REL: released -> FLIGHT; not released and no_balls=1 -> DONE; otherwise -> DONE (no release means supply exhausted).
REQ-023 FLIGHT: exit_blue edge -> TRIG BLUE; exit_red edge -> TRIG RED; intercept edge -> HALT; in_flight=1 only here.
REQ-024 exit_blue and exit_red edges in same cycle -> ERROR, fault=1; intercept edge coincident with an exit edge -> HALT wins.
REQ-025 Edges of exit/intercept outside FLIGHT ignored, no state effect.
REQ-026 HALT and DONE: triggers low; start edge -> restart per REQ-019.
REQ-027 ERROR: triggers low, fault held; leaves only via rst_n or start edge (-> IDLE semantics of REQ-019).
REQ-028 drops saturates at 31, never wraps.

Reset
REQ-029 rst_n low: state IDLE, both triggers 0, in_flight 0, fault 0, drops 0, edge registers 0, timeout counter 0; immediate, independent of clk.
REQ-030 Reset mid-pulse terminates trigger asynchronously; first post-reset cycle is IDLE with no spurious edge detected from inputs already high.

Configuration
REQ-031 Macro LEVER_CTRL_WATCHDOG_EN defined: counter runs in FLIGHT, cleared on entry; reaching TIMEOUT_CYCLES -> ERROR, fault=1.
REQ-032 Macro undefined: no counter logic; FLIGHT waits indefinitely; fault set only by dual exit.

Structure
REQ-033 Shared package tt_pkg holds state enum, COLOR_BLUE=0 / COLOR_RED=1 constants, drops width constant.
REQ-034 One sub-module tt_edge_det (registered rising-edge detector, async active-low reset) instantiated per edge-sensed input.

Verification
REQ-035 Start edge, blue_ball high in TRIG -> blue_trigger high exactly 4 clocks, state FLIGHT, drops=1.
REQ-036 In FLIGHT pulse exit_red -> red_trigger 4 clocks, drops=2; exit_blue next -> blue_trigger, drops=3.
REQ-037 Trigger with no release and no_balls=1 -> state DONE, triggers low, drops unchanged.
REQ-038 exit_blue and exit_red rise same cycle in FLIGHT -> ERROR, fault=1; intercept plus exit same cycle -> HALT.
REQ-039 With LEVER_CTRL_WATCHDOG_EN, no exit for 1024 clocks -> ERROR at cycle 1024; without macro, still FLIGHT after 5000 clocks.
REQ-040 rst_n low during 2nd trigger clock -> trigger drops immediately, outputs at reset values, inputs held high produce no edge after release.
